// File: rtl/sipo_frame.sv
// Serial-in parallel-out framer with a one-word holding register.
// Words move out over a valid/ready handshake; a word that completes while the holding register is still full is dropped and flagged.
module sipo_frame #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  localparam int CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             clear,
  output logic [WIDTH-1:0] pout,
  output logic             pout_valid,
  input  logic             pout_ready,
  output logic [CW-1:0]    bit_cnt,
  output logic             overrun
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] sreg_nxt;
  logic [WIDTH-1:0] shifted;
  logic [CW-1:0]    cnt_nxt;
  logic [WIDTH-1:0] pout_nxt;
  logic             pvld_nxt;
  logic             ovr_nxt;
  logic             take;
  logic             done;
  logic             xfer;
  logic             room;

  // Sampled bit is folded in from the side chosen by the bit order.
  always_comb begin
    shifted = sreg;
    if (MSB_FIRST) begin
      shifted = {sreg[WIDTH-2:0], sin};
    end else begin
      shifted = {sin, sreg[WIDTH-1:1]};
    end
  end

  // Handshake and word-complete qualifiers; clear swallows the bit.
  always_comb begin
    take = sin_valid & ~clear;
    done = take & (bit_cnt == LAST);
    xfer = pout_valid & pout_ready;
    room = ~pout_valid | pout_ready;
  end

  // Next state of the shift register and bit counter.
  always_comb begin
    sreg_nxt = sreg;
    cnt_nxt  = bit_cnt;
    unique case (1'b1)
      clear: begin
        sreg_nxt = '0;
        cnt_nxt  = '0;
      end
      take && done: begin
        sreg_nxt = shifted;
        cnt_nxt  = '0;
      end
      take && !done: begin
        sreg_nxt = shifted;
        cnt_nxt  = bit_cnt + 1'b1;
      end
      default: begin
        sreg_nxt = sreg;
        cnt_nxt  = bit_cnt;
      end
    endcase
  end

  // Holding register: load, drop on full, drain on transfer, else hold.
  always_comb begin
    pout_nxt = pout;
    pvld_nxt = pout_valid;
    ovr_nxt  = overrun;
    unique case (1'b1)
      done && room: begin
        pout_nxt = shifted;
        pvld_nxt = 1'b1;
      end
      done && !room: begin
        ovr_nxt = 1'b1;
      end
      xfer && !done: begin
        pvld_nxt = 1'b0;
      end
      default: begin
        pout_nxt = pout;
      end
    endcase
    if (clear) begin
      ovr_nxt = 1'b0;
    end
  end

  // Collection state, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg    <= '0;
      bit_cnt <= '0;
    end else begin
      sreg    <= sreg_nxt;
      bit_cnt <= cnt_nxt;
    end
  end

  // Output word, its valid flag and the sticky overrun flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pout       <= '0;
      pout_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      pout       <= pout_nxt;
      pout_valid <= pvld_nxt;
      overrun    <= ovr_nxt;
    end
  end

endmodule

// File: tb/tb_sipo_frame.sv
// Directed bench for sipo_frame: an MSB-first and an LSB-first instance share stimulus.
// Expected words are queued when their last bit is driven and popped when checked.
module tb_sipo_frame;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sin = 1'b0;
  logic       sin_valid = 1'b0;
  logic       clear = 1'b0;
  logic       pout_ready = 1'b0;
  logic [7:0] pout_m;
  logic [7:0] pout_l;
  logic       pv_m;
  logic       pv_l;
  logic [2:0] cnt_m;
  logic [2:0] cnt_l;
  logic       ovr_m;
  logic       ovr_l;

  int n_assert = 0;
  int n_fail = 0;

  logic [7:0] q_m[$];
  logic [7:0] q_l[$];
  logic [7:0] held_m;
  logic [7:0] held_l;

  sipo_frame #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid),
    .clear(clear), .pout(pout_m), .pout_valid(pv_m),
    .pout_ready(pout_ready), .bit_cnt(cnt_m), .overrun(ovr_m)
  );

  sipo_frame #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid),
    .clear(clear), .pout(pout_l), .pout_valid(pv_l),
    .pout_ready(pout_ready), .bit_cnt(cnt_l), .overrun(ovr_l)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic b, input logic v);
    sin = b;
    sin_valid = v;
    @(posedge clk);
    #1;
    sin_valid = 1'b0;
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_pout_m"}, 32'(pout_m), 32'h0);
    chk({tag, "_pv_m"}, 32'(pv_m), 32'h0);
    chk({tag, "_cnt_m"}, 32'(cnt_m), 32'h0);
    chk({tag, "_ovr_m"}, 32'(ovr_m), 32'h0);
    chk({tag, "_pout_l"}, 32'(pout_l), 32'h0);
    chk({tag, "_pv_l"}, 32'(pv_l), 32'h0);
  endtask

  task automatic pop_chk(input string tag);
    logic [7:0] em;
    logic [7:0] el;
    if (q_m.size() == 0 || q_l.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'(q_m.size()), 32'h1);
    end else begin
      em = q_m.pop_front();
      el = q_l.pop_front();
      held_m = em;
      held_l = el;
      chk({tag, "_pv_m"}, 32'(pv_m), 32'h1);
      chk({tag, "_pout_m"}, 32'(pout_m), 32'(em));
      chk({tag, "_pv_l"}, 32'(pv_l), 32'h1);
      chk({tag, "_pout_l"}, 32'(pout_l), 32'(el));
      chk({tag, "_cnt"}, 32'(cnt_m), 32'h0);
    end
  endtask

  // Sends w MSB-first on the wire; optional random idle gaps with
  // bit_cnt checked frozen at the number of bits collected so far.
  task automatic send_word(input logic [7:0] w, input bit gaps);
    for (int i = 7; i >= 0; i--) begin
      if (gaps) begin
        int n;
        n = $urandom_range(1, 3);
        repeat (n) begin
          step(1'b1, 1'b0);
          chk("gap_cnt", 32'(cnt_m), 32'(7 - i));
        end
      end
      step(w[i], 1'b1);
    end
  endtask

  initial begin
    #3;
    all_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Consecutive bits 1,0,1,1,0,0,1,0.
    for (int i = 7; i >= 1; i--) step(8'hB2 >> i, 1'b1);
    chk("pre_last_pv", 32'(pv_m), 32'h0);
    chk("pre_last_cnt", 32'(cnt_m), 32'h7);
    q_m.push_back(8'hB2);
    q_l.push_back(8'h4D);
    step(1'b0, 1'b1);
    pop_chk("word_b2");

    // Held while not ready, then drained.
    step(1'b0, 1'b0);
    chk("hold_pout", 32'(pout_m), 32'hB2);
    chk("hold_pv", 32'(pv_m), 32'h1);
    pout_ready = 1'b1;
    step(1'b0, 1'b0);
    pout_ready = 1'b0;
    chk("drain_pv_m", 32'(pv_m), 32'h0);
    chk("drain_pv_l", 32'(pv_l), 32'h0);

    // Same bits with idle gaps.
    q_m.push_back(8'hB2);
    q_l.push_back(8'h4D);
    send_word(8'hB2, 1'b1);
    pop_chk("gap_b2");

    // Second word while full: dropped, overrun set.
    send_word(8'hFF, 1'b0);
    chk("ovr_pout_m", 32'(pout_m), 32'(held_m));
    chk("ovr_pout_l", 32'(pout_l), 32'(held_l));
    chk("ovr_flag", 32'(ovr_m), 32'h1);
    chk("ovr_pv", 32'(pv_m), 32'h1);
    step(1'b0, 1'b0);
    chk("ovr_sticky", 32'(ovr_m), 32'h1);

    // Clear with a concurrent valid bit: bit discarded.
    step(1'b1, 1'b1);
    chk("pre_clr_cnt", 32'(cnt_m), 32'h1);
    clear = 1'b1;
    step(1'b1, 1'b1);
    clear = 1'b0;
    chk("clr_ovr", 32'(ovr_m), 32'h0);
    chk("clr_cnt", 32'(cnt_m), 32'h0);
    chk("clr_pv", 32'(pv_m), 32'h1);
    chk("clr_pout", 32'(pout_m), 32'(held_m));

    // New word completes on the transfer edge: no bubble.
    for (int i = 7; i >= 1; i--) begin
      step(8'h0F >> i, 1'b1);
      chk("b2b_pv_hold", 32'(pv_m), 32'h1);
    end
    q_m.push_back(8'h0F);
    q_l.push_back(8'hF0);
    pout_ready = 1'b1;
    step(1'b1, 1'b1);
    pout_ready = 1'b0;
    pop_chk("b2b_0f");
    chk("b2b_ovr", 32'(ovr_m), 32'h0);

    pout_ready = 1'b1;
    step(1'b0, 1'b0);
    pout_ready = 1'b0;
    chk("drain2_pv", 32'(pv_m), 32'h0);

    // Reset mid-cycle after 3 bits.
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    chk("pre_rst_cnt", 32'(cnt_m), 32'h3);
    #2;
    rst = 1'b1;
    #1;
    all_zero("midrst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    q_m.push_back(8'hA5);
    q_l.push_back(8'hA5);
    send_word(8'hA5, 1'b0);
    pop_chk("post_rst_a5");
    chk("post_rst_ovr", 32'(ovr_m), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
